// File: rtl/module_sp.sv
// Serial-to-parallel lane receiver: recovers byte alignment from COM idles,
// declares the lane active after SYNC_COUNT aligned COMs, then delivers data bytes.
module module_sp #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

  localparam logic [3:0] SYNC_N = SYNC_COUNT[3:0];

  state_t     state;
  logic [7:0] sr;
  logic [7:0] nxt;
  logic [2:0] bit_cnt;
  logic [3:0] bc_cnt;
  logic       boundary;
  logic       is_com;

  // nxt is the byte including the bit sampled on this edge
  assign nxt      = {sr[6:0], data_in};
  assign boundary = (bit_cnt == 3'd7);
  assign is_com   = (nxt == COM);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      sr        <= 8'h00;
      bit_cnt   <= 3'd0;
      bc_cnt    <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr <= nxt;
      unique case (state)
        SEARCH: begin
          // Slide one bit per cycle until a COM lines up; bit 0 of the next byte follows
          if (is_com) begin
            bit_cnt <= 3'd0;
            bc_cnt  <= 4'd1;
            if (SYNC_COUNT == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_com) begin
              bc_cnt <= bc_cnt + 4'd1;
              if (bc_cnt + 4'd1 == SYNC_N) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              // False or lost alignment: drop back and resume sliding next cycle
              state  <= SEARCH;
              bc_cnt <= 4'd0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_com) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= nxt;
              valid_out <= 1'b1;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_module_sp.sv
// Bench for module_sp: directed bit streams, scoreboard of expected data bytes
// popped by per-DUT monitors, plus directed checks on active timing and reset.
module tb_module_sp;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out,  data_out1;
  logic       valid_out, valid_out1;
  logic       active,    active1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_q1[$];
  int         vcnt  = 0;
  int         vcnt1 = 0;
  bit         en1   = 0;

  module_sp #(.COM(8'hBC), .SYNC_COUNT(4)) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .active(active)
  );

  module_sp #(.COM(8'hBC), .SYNC_COUNT(1)) dut1 (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(data_out1), .valid_out(valid_out1), .active(active1)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one bit away from the edge, then return just after the edge that samples it
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b0;
  endtask

  // Each valid byte is held for exactly 8 cycles, so one pop per 8-cycle valid window
  always @(negedge clk_32f) begin
    if (!valid_out) vcnt = 0;
    else begin
      if (vcnt == 0) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_byte: got %02h expected none at %0t", data_out, $time);
        end else chk("byte", data_out, exp_q.pop_front());
      end
      vcnt = (vcnt + 1) % 8;
    end
  end

  always @(negedge clk_32f) begin
    if (!en1 || !valid_out1) vcnt1 = 0;
    else begin
      if (vcnt1 == 0) begin
        if (exp_q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_byte1: got %02h expected none at %0t", data_out1, $time);
        end else chk("byte1", data_out1, exp_q1.pop_front());
      end
      vcnt1 = (vcnt1 + 1) % 8;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    data_in = 1'b0;
    do_reset();
    chk("reset_active", {7'd0, active}, 8'h00);
    chk("reset_valid", {7'd0, valid_out}, 8'h00);
    chk("reset_data", data_out, 8'h00);

    // Clean sync: active must rise exactly after the 32nd bit
    repeat (3) send_byte(8'hBC);
    send_bits(8'hBC, 7);
    chk("sync_active_early", {7'd0, active}, 8'h00);
    send_bit(1'b0);
    chk("sync_active", {7'd0, active}, 8'h01);
    chk("sync_valid", {7'd0, valid_out}, 8'h00);

    // Data after sync
    exp_q.push_back(8'hA5); send_byte(8'hA5);
    exp_q.push_back(8'h3C); send_byte(8'h3C);
    send_byte(8'hBC);
    chk("idle_valid", {7'd0, valid_out}, 8'h00);
    chk("idle_hold", data_out, 8'h3C);

    // Misalignment: three stray bits then COMs; active after bit 35
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (3) send_byte(8'hBC);
    send_bits(8'hBC, 7);
    chk("mis_active_early", {7'd0, active}, 8'h00);
    send_bit(1'b0);
    chk("mis_active", {7'd0, active}, 8'h01);
    exp_q.push_back(8'h5A); send_byte(8'h5A);
    exp_q.push_back(8'hFF); send_byte(8'hFF);
    send_byte(8'hBC);
    chk("mis_idle_valid", {7'd0, valid_out}, 8'h00);

    // Broken sync: the 0x00 sends it back to SEARCH
    do_reset();
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h00);
    chk("broken_active0", {7'd0, active}, 8'h00);
    repeat (3) send_byte(8'hBC);
    send_bits(8'hBC, 7);
    chk("broken_active_early", {7'd0, active}, 8'h00);
    send_bit(1'b0);
    chk("broken_active", {7'd0, active}, 8'h01);

    // Reset mid-data
    do_reset();
    repeat (4) send_byte(8'hBC);
    exp_q.push_back(8'hA5); send_byte(8'hA5);
    send_bits(8'h3C, 4);
    chk("pre_rst_valid", {7'd0, valid_out}, 8'h01);
    #2 reset = 1'b1;
    #1;
    chk("async_active", {7'd0, active}, 8'h00);
    chk("async_valid", {7'd0, valid_out}, 8'h00);
    chk("async_data", data_out, 8'h00);
    repeat (2) @(posedge clk_32f);
    #1 reset = 1'b0;
    repeat (3) send_byte(8'hBC);
    send_bits(8'hBC, 7);
    chk("rst_active_early", {7'd0, active}, 8'h00);
    send_bit(1'b0);
    chk("rst_active", {7'd0, active}, 8'h01);
    exp_q.push_back(8'h81); send_byte(8'h81);
    send_byte(8'hBC);

    // SYNC_COUNT=1 instance: one COM is enough
    do_reset();
    en1 = 1'b1;
    send_bits(8'hBC, 7);
    chk("sc1_active_early", {7'd0, active1}, 8'h00);
    send_bit(1'b0);
    chk("sc1_active", {7'd0, active1}, 8'h01);
    exp_q1.push_back(8'h42); send_byte(8'h42);
    send_byte(8'hBC);
    chk("sc1_idle_valid", {7'd0, valid_out1}, 8'h00);
    chk("sc1_idle_hold", data_out1, 8'h42);

    repeat (2) @(posedge clk_32f);
    chk("queue_empty", 8'(exp_q.size()), 8'h00);
    chk("queue1_empty", 8'(exp_q1.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
